alu_sru_seq: RTL and testbench

Synchronous sequencer for the serial shift/rotate unit (SRU). It accepts a shift/rotate request from the microcode control unit, latches the operation fields, and issues one single-bit step per `clk2` cycle for the requested distance. It drives the SRU's B-register and FL write strobes and holds the control unit in a wait state until the operation completes. It replaces the SRU's free-running clock-multiplied step generation with a single-clock, cycle-exact schedule.

---
 rtl/alu_sru_seq_pkg.sv | 12 +
 rtl/alu_sru_seq_step_counter.sv | 30 +++
 rtl/alu_sru_seq.sv | 104 ++++++++++
 tb/tb_alu_sru_seq.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/alu_sru_seq_pkg.sv
// Shared state encodings and default distance width for the SRU step sequencer.
package alu_sru_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } sru_state_t;

  localparam int DIST_W_DEF = 4;

endpackage

// File: rtl/alu_sru_seq_step_counter.sv
// Loadable down-counter of remaining SRU steps; clear beats load beats decrement.
// Single-cycle update, no flow control; is_one flags the final step.
module sru_step_counter #(
  parameter int W = 5
) (
  input  logic         clk2,
  input  logic         reset,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         is_one
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk2) begin
    if (reset || clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec) begin
      count <= count - ONE;
    end
  end

  assign is_one = (count == ONE);

endmodule

// File: rtl/alu_sru_seq.sv
// Sequencer for the serial shift/rotate unit: latches an op, then one step per clk2 for N cycles, then a done pulse.
// Steps start the cycle after accept; the control unit is stalled (nwait low) while steps remain.
module alu_sru_seq
  import alu_sru_seq_pkg::*;
#(
  parameter int DIST_W      = DIST_W_DEF,
  parameter int ZERO_IS_MAX = 0
) (
  input  logic              clk2,
  input  logic              reset,
  input  logic              req,
  input  logic              abort,
  input  logic              op_arithmetic,
  input  logic              op_rotate,
  input  logic              op_right,
  input  logic [DIST_W-1:0] op_dist,
  output logic              sru_arithmetic,
  output logic              sru_rotate,
  output logic              sru_right,
  output logic              step,
  output logic              fl_we,
  output logic              busy,
  output logic              done,
  output logic              nwait,
  output logic [DIST_W:0]   remaining
);

  sru_state_t      state;
  sru_state_t      state_nxt;
  sru_state_t      start_state;
  logic [DIST_W:0] step_cnt;
  logic            accept;
  logic            is_one;

  // Distance 0 optionally stands for the full 2^DIST_W run.
  always_comb begin
    step_cnt = {1'b0, op_dist};
    if ((ZERO_IS_MAX != 0) && (op_dist == '0)) begin
      step_cnt = {1'b1, {DIST_W{1'b0}}};
    end
  end

  assign start_state = (step_cnt == '0) ? ST_DONE : ST_SHIFT;
  assign accept      = req && !abort && ((state == ST_IDLE) || (state == ST_DONE));

  always_ff @(posedge clk2) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) state_nxt = start_state;
      end
      ST_SHIFT: begin
        if (abort)       state_nxt = ST_IDLE;
        else if (is_one) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (accept) state_nxt = start_state;
        else        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk2) begin
    if (reset) begin
      sru_arithmetic <= 1'b0;
      sru_rotate     <= 1'b0;
      sru_right      <= 1'b0;
    end else if (accept) begin
      sru_arithmetic <= op_arithmetic;
      sru_rotate     <= op_rotate;
      sru_right      <= op_right;
    end
  end

  sru_step_counter #(
    .W (DIST_W + 1)
  ) u_cnt (
    .clk2     (clk2),
    .reset    (reset),
    .clr      (abort),
    .load     (accept),
    .load_val (step_cnt),
    .dec      (state == ST_SHIFT),
    .count    (remaining),
    .is_one   (is_one)
  );

  // Strobes come from the state register only, never from req.
  assign step  = (state == ST_SHIFT);
  assign busy  = step;
  assign fl_we = step && sru_rotate;
  assign done  = (state == ST_DONE);
  assign nwait = !busy;

endmodule

// File: tb/tb_alu_sru_seq.sv
// Directed bench: dut0 treats distance 0 as no steps, dut1 as the full 16-step run; both share stimulus.
module tb_alu_sru_seq;

  logic       clk2 = 1'b0;
  logic       reset = 1'b0;
  logic       req = 1'b0;
  logic       abort = 1'b0;
  logic       op_arithmetic = 1'b0;
  logic       op_rotate = 1'b0;
  logic       op_right = 1'b0;
  logic [3:0] op_dist = 4'd0;

  logic       ar0, ro0, ri0, step0, fl0, busy0, done0, nw0;
  logic [4:0] rem0;
  logic       ar1, ro1, ri1, step1, fl1, busy1, done1, nw1;
  logic [4:0] rem1;

  int checks = 0;
  int errors = 0;

  // {step, fl_we, busy, done, nwait}
  logic [4:0] st0, st1;
  logic [2:0] ops0, ops1;
  assign st0  = {step0, fl0, busy0, done0, nw0};
  assign st1  = {step1, fl1, busy1, done1, nw1};
  assign ops0 = {ar0, ro0, ri0};
  assign ops1 = {ar1, ro1, ri1};

  localparam logic [4:0] S_IDLE  = 5'b00001;
  localparam logic [4:0] S_SHIFT = 5'b10100;
  localparam logic [4:0] S_ROT   = 5'b11100;
  localparam logic [4:0] S_DONE  = 5'b00011;

  alu_sru_seq #(.DIST_W(4), .ZERO_IS_MAX(0)) dut0 (
    .clk2(clk2), .reset(reset), .req(req), .abort(abort),
    .op_arithmetic(op_arithmetic), .op_rotate(op_rotate), .op_right(op_right), .op_dist(op_dist),
    .sru_arithmetic(ar0), .sru_rotate(ro0), .sru_right(ri0),
    .step(step0), .fl_we(fl0), .busy(busy0), .done(done0), .nwait(nw0), .remaining(rem0)
  );

  alu_sru_seq #(.DIST_W(4), .ZERO_IS_MAX(1)) dut1 (
    .clk2(clk2), .reset(reset), .req(req), .abort(abort),
    .op_arithmetic(op_arithmetic), .op_rotate(op_rotate), .op_right(op_right), .op_dist(op_dist),
    .sru_arithmetic(ar1), .sru_rotate(ro1), .sru_right(ri1),
    .step(step1), .fl_we(fl1), .busy(busy1), .done(done1), .nwait(nw1), .remaining(rem1)
  );

  always #5 clk2 = ~clk2;

  task automatic tick();
    @(posedge clk2);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 1'b1; abort = 1'b0;
    op_arithmetic = 1'b1; op_rotate = 1'b1; op_right = 1'b1; op_dist = 4'd5;
    tick();
    tick();
    checks++; if (st0 !== S_IDLE) begin errors++; $display("FAIL reset_strobes got=%b exp=%b", st0, S_IDLE); end
    checks++; if (rem0 !== 5'd0) begin errors++; $display("FAIL reset_remaining got=%0d exp=0", rem0); end
    checks++; if (ops0 !== 3'b000) begin errors++; $display("FAIL reset_ops got=%b exp=000", ops0); end
    reset = 1'b0; req = 1'b0;
    op_arithmetic = 1'b0; op_rotate = 1'b0; op_right = 1'b0; op_dist = 4'd0;
    tick();
    checks++; if (st0 !== S_IDLE) begin errors++; $display("FAIL post_reset_idle got=%b exp=%b", st0, S_IDLE); end
  endtask

  task automatic test_shift_left5();
    op_dist = 4'd5; op_rotate = 1'b0; op_right = 1'b0; req = 1'b1;
    tick();
    req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (st0 !== S_SHIFT) begin errors++; $display("FAIL shl5_strobe cyc=%0d got=%b exp=%b", i, st0, S_SHIFT); end
      checks++; if (rem0 !== 5'(5 - i)) begin errors++; $display("FAIL shl5_remaining cyc=%0d got=%0d exp=%0d", i, rem0, 5 - i); end
      tick();
    end
    checks++; if (st0 !== S_DONE) begin errors++; $display("FAIL shl5_done got=%b exp=%b", st0, S_DONE); end
    checks++; if (rem0 !== 5'd0) begin errors++; $display("FAIL shl5_rem_end got=%0d exp=0", rem0); end
    tick();
    checks++; if (st0 !== S_IDLE) begin errors++; $display("FAIL shl5_idle got=%b exp=%b", st0, S_IDLE); end
  endtask

  task automatic test_rotate_right3();
    op_dist = 4'd3; op_rotate = 1'b1; op_right = 1'b1; op_arithmetic = 1'b0; req = 1'b1;
    tick();
    req = 1'b0; op_rotate = 1'b0; op_right = 1'b0; op_arithmetic = 1'b1; op_dist = 4'd7;
    for (int i = 0; i < 3; i++) begin
      checks++; if (st0 !== S_ROT) begin errors++; $display("FAIL ror3_strobe cyc=%0d got=%b exp=%b", i, st0, S_ROT); end
      checks++; if (ops0 !== 3'b011) begin errors++; $display("FAIL ror3_latched cyc=%0d got=%b exp=011", i, ops0); end
      tick();
    end
    checks++; if (st0 !== S_DONE) begin errors++; $display("FAIL ror3_done got=%b exp=%b", st0, S_DONE); end
    tick();
    checks++; if (ops0 !== 3'b011) begin errors++; $display("FAIL ror3_held got=%b exp=011", ops0); end
    op_arithmetic = 1'b0;
  endtask

  task automatic test_dist_zero();
    int steps1;
    steps1 = 0;
    op_dist = 4'd0; op_rotate = 1'b0; req = 1'b1;
    tick();
    req = 1'b0;
    checks++; if (st0 !== S_DONE) begin errors++; $display("FAIL dist0_done got=%b exp=%b", st0, S_DONE); end
    checks++; if (rem1 !== 5'd16) begin errors++; $display("FAIL dist0max_load got=%0d exp=16", rem1); end
    for (int i = 0; i < 16; i++) begin
      if (step1 === 1'b1) steps1++;
      if (step0 === 1'b1) begin
        checks++; errors++; $display("FAIL dist0_step cyc=%0d got=1 exp=0", i);
      end
      tick();
    end
    checks++; if (steps1 != 16) begin errors++; $display("FAIL dist0max_steps got=%0d exp=16", steps1); end
    checks++; if (st1 !== S_DONE) begin errors++; $display("FAIL dist0max_done got=%b exp=%b", st1, S_DONE); end
    checks++; if (st0 !== S_IDLE) begin errors++; $display("FAIL dist0_idle got=%b exp=%b", st0, S_IDLE); end
    tick();
  endtask

  task automatic test_back_to_back();
    op_dist = 4'd2; req = 1'b1;
    tick();
    checks++; if (st0 !== S_SHIFT || rem0 !== 5'd2) begin errors++; $display("FAIL b2b_k1 got=%b/%0d exp=%b/2", st0, rem0, S_SHIFT); end
    op_dist = 4'd1;
    tick();
    checks++; if (st0 !== S_SHIFT || rem0 !== 5'd1) begin errors++; $display("FAIL b2b_k2 got=%b/%0d exp=%b/1", st0, rem0, S_SHIFT); end
    tick();
    checks++; if (st0 !== S_DONE) begin errors++; $display("FAIL b2b_k3 got=%b exp=%b", st0, S_DONE); end
    tick();
    req = 1'b0;
    checks++; if (st0 !== S_SHIFT || rem0 !== 5'd1) begin errors++; $display("FAIL b2b_k4 got=%b/%0d exp=%b/1", st0, rem0, S_SHIFT); end
    tick();
    checks++; if (st0 !== S_DONE) begin errors++; $display("FAIL b2b_k5 got=%b exp=%b", st0, S_DONE); end
    tick();
    checks++; if (st0 !== S_IDLE) begin errors++; $display("FAIL b2b_idle got=%b exp=%b", st0, S_IDLE); end
  endtask

  task automatic test_abort();
    op_dist = 4'd7; req = 1'b1;
    tick();
    req = 1'b0;
    tick();
    checks++; if (st0 !== S_SHIFT || rem0 !== 5'd6) begin errors++; $display("FAIL abort_pre got=%b/%0d exp=%b/6", st0, rem0, S_SHIFT); end
    abort = 1'b1; req = 1'b1;
    tick();
    checks++; if (st0 !== S_IDLE) begin errors++; $display("FAIL abort_strobes got=%b exp=%b", st0, S_IDLE); end
    checks++; if (rem0 !== 5'd0) begin errors++; $display("FAIL abort_remaining got=%0d exp=0", rem0); end
    tick();
    checks++; if (st0 !== S_IDLE) begin errors++; $display("FAIL abort_blocks_req got=%b exp=%b", st0, S_IDLE); end
    abort = 1'b0; req = 1'b0;
    tick();
    checks++; if (st0 !== S_IDLE) begin errors++; $display("FAIL abort_no_done got=%b exp=%b", st0, S_IDLE); end
  endtask

  task automatic test_reset_mid_shift();
    op_dist = 4'd7; op_rotate = 1'b1; op_right = 1'b1; op_arithmetic = 1'b1; req = 1'b1;
    tick();
    req = 1'b0;
    tick();
    checks++; if (st0 !== S_ROT) begin errors++; $display("FAIL rst_mid_pre got=%b exp=%b", st0, S_ROT); end
    reset = 1'b1; req = 1'b1; abort = 1'b1;
    tick();
    reset = 1'b0; req = 1'b0; abort = 1'b0;
    checks++; if (st0 !== S_IDLE) begin errors++; $display("FAIL rst_mid_strobes got=%b exp=%b", st0, S_IDLE); end
    checks++; if (rem0 !== 5'd0) begin errors++; $display("FAIL rst_mid_remaining got=%0d exp=0", rem0); end
    checks++; if (ops0 !== 3'b000) begin errors++; $display("FAIL rst_mid_ops got=%b exp=000", ops0); end
    tick();
    checks++; if (st0 !== S_IDLE || st1 !== S_IDLE) begin errors++; $display("FAIL rst_mid_idle got=%b/%b exp=%b", st0, st1, S_IDLE); end
  endtask

  initial begin
    test_reset();
    test_shift_left5();
    test_rotate_right3();
    test_dist_zero();
    test_back_to_back();
    test_abort();
    test_reset_mid_shift();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
